global_reset_sequencer: RTL and testbench



---
 rtl/global_reset_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_global_reset_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/global_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : global_reset_sequencer
//  Description : Merges maskable asynchronous reset sources and a software
//                request. Holds the PLL in reset, then waits for lock with a
//                timeout. Finally releases a chain of active-low domain
//                resets one at a time, with a fixed gap between releases.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk             free-running reference clock
//    reset_n         asynchronous active-low master reset
//    resetn_sources  asynchronous active-low reset requests (one per source)
//    source_mask     1 = source participates; quasi-static, clk domain
//    sw_reset_req    synchronous single-cycle software reset request
//    pll_locked      asynchronous PLL lock indicator
//    pll_resetn      active-low PLL reset
//    stage_resetn    active-low domain resets, bit 0 released first
//    sequence_done   high while every stage is released
//    lock_timeout    sticky flag: a lock wait expired since reset_n
// ============================================================================
module global_reset_sequencer #(
    parameter int SOURCES_WIDTH      = 2,
    parameter int STAGES             = 4,
    parameter int COUNTER_WIDTH      = 16,
    parameter int STAGE_GAP          = 16,
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_TIMEOUT_WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [SOURCES_WIDTH-1:0] resetn_sources,
    input  logic [SOURCES_WIDTH-1:0] source_mask,
    input  logic                     sw_reset_req,
    input  logic                     pll_locked,
    output logic                     pll_resetn,
    output logic [STAGES-1:0]        stage_resetn,
    output logic                     sequence_done,
    output logic                     lock_timeout
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int c_IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    localparam logic [COUNTER_WIDTH-1:0]      c_HOLD_LAST  = '1;
    localparam logic [LOCK_TIMEOUT_WIDTH-1:0] c_LOCK_LAST  = '1;
    localparam logic [c_GAP_W-1:0]            c_GAP_LAST   = c_GAP_W'(STAGE_GAP - 1);
    // Index of the stage whose gap expiry releases the final stage.
    localparam logic [c_IDX_W-1:0]            c_IDX_PENULT = c_IDX_W'((STAGES > 1) ? STAGES - 2 : 0);
    localparam logic [STAGES-1:0]             c_FIRST_STAGE = STAGES'(1);
    localparam bit                            c_SINGLE_STAGE = (STAGES == 1);

    localparam logic [1:0] c_ST_HOLD     = 2'd0;
    localparam logic [1:0] c_ST_PLL_WAIT = 2'd1;
    localparam logic [1:0] c_ST_STAGE    = 2'd2;
    localparam logic [1:0] c_ST_DONE     = 2'd3;

    // ------------------------------------------------------------------------
    // Input synchronisers. Flops clear to 0, which reads as "source active"
    // and "not locked", so the block comes out of reset safely held.
    // ------------------------------------------------------------------------
    logic [SOURCES_WIDTH-1:0] w_src_sync;
    logic                     w_lock_sync;

    generate
        for (genvar gi = 0; gi < SOURCES_WIDTH; gi++) begin : g_src_sync
            logic [SYNC_STAGES-1:0] r_chain;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_chain <= '0;
                end else begin
                    r_chain <= {r_chain[SYNC_STAGES-2:0], resetn_sources[gi]};
                end
            end

            assign w_src_sync[gi] = r_chain[SYNC_STAGES-1];
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_lock_chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_chain <= '0;
        end else begin
            r_lock_chain <= {r_lock_chain[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign w_lock_sync = r_lock_chain[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Merged reset request: any enabled source low, or a software pulse.
    // ------------------------------------------------------------------------
    logic w_req;

    assign w_req = (|(source_mask & ~w_src_sync)) | sw_reset_req;

    // ------------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------------
    logic [1:0]                    r_state;
    logic [COUNTER_WIDTH-1:0]      r_hold_cnt;
    logic [LOCK_TIMEOUT_WIDTH-1:0] r_lock_cnt;
    logic [c_GAP_W-1:0]            r_gap_cnt;
    logic [c_IDX_W-1:0]            r_idx;
    logic                          r_pll_resetn;
    logic [STAGES-1:0]             r_stage_resetn;
    logic                          r_sequence_done;
    logic                          r_lock_timeout;

    // A request aborts anything past HOLD; losing lock aborts once any stage
    // has been released. Lock expiry only counts when neither a request nor
    // a lock arrived in the same cycle, so a request never sets the flag.
    logic w_running;
    logic w_abort;
    logic w_lock_expired;
    logic w_enter_hold;

    assign w_running      = (r_state == c_ST_STAGE) || (r_state == c_ST_DONE);
    assign w_abort        = (r_state != c_ST_HOLD) && (w_req || (w_running && !w_lock_sync));
    assign w_lock_expired = (r_state == c_ST_PLL_WAIT) && !w_req && !w_lock_sync &&
                            (r_lock_cnt == c_LOCK_LAST);
    assign w_enter_hold   = w_abort || w_lock_expired;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= c_ST_HOLD;
            r_hold_cnt      <= '0;
            r_lock_cnt      <= '0;
            r_gap_cnt       <= '0;
            r_idx           <= '0;
            r_pll_resetn    <= 1'b0;
            r_stage_resetn  <= '0;
            r_sequence_done <= 1'b0;
            r_lock_timeout  <= 1'b0;
        end else if (w_enter_hold) begin
            r_state         <= c_ST_HOLD;
            r_hold_cnt      <= '0;
            r_lock_cnt      <= '0;
            r_gap_cnt       <= '0;
            r_idx           <= '0;
            r_pll_resetn    <= 1'b0;
            r_stage_resetn  <= '0;
            r_sequence_done <= 1'b0;
            if (w_lock_expired) begin
                r_lock_timeout <= 1'b1;
            end
        end else begin
            case (r_state)
                c_ST_HOLD: begin
                    r_pll_resetn    <= 1'b0;
                    r_stage_resetn  <= '0;
                    r_sequence_done <= 1'b0;
                    // Any request restarts the hold window from zero.
                    if (w_req) begin
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt == c_HOLD_LAST) begin
                        r_hold_cnt   <= '0;
                        r_lock_cnt   <= '0;
                        r_pll_resetn <= 1'b1;
                        r_state      <= c_ST_PLL_WAIT;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + COUNTER_WIDTH'(1);
                    end
                end

                c_ST_PLL_WAIT: begin
                    if (w_lock_sync) begin
                        r_lock_cnt     <= '0;
                        r_gap_cnt      <= '0;
                        r_idx          <= '0;
                        r_stage_resetn <= c_FIRST_STAGE;
                        if (c_SINGLE_STAGE) begin
                            r_sequence_done <= 1'b1;
                            r_state         <= c_ST_DONE;
                        end else begin
                            r_state <= c_ST_STAGE;
                        end
                    end else begin
                        r_lock_cnt <= r_lock_cnt + LOCK_TIMEOUT_WIDTH'(1);
                    end
                end

                c_ST_STAGE: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_gap_cnt <= '0;
                        r_idx     <= r_idx + c_IDX_W'(1);
                        // Stages release in order, so the next release is a
                        // one shifted in above the already-released bits.
                        r_stage_resetn <= (r_stage_resetn << 1) | c_FIRST_STAGE;
                        if (r_idx == c_IDX_PENULT) begin
                            r_sequence_done <= 1'b1;
                            r_state         <= c_ST_DONE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                    end
                end

                c_ST_DONE: begin
                    r_sequence_done <= 1'b1;
                end

                default: begin
                    r_state <= c_ST_HOLD;
                end
            endcase
        end
    end

    assign pll_resetn    = r_pll_resetn;
    assign stage_resetn  = r_stage_resetn;
    assign sequence_done = r_sequence_done;
    assign lock_timeout  = r_lock_timeout;

endmodule
`default_nettype wire

// File: tb/tb_global_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_global_reset_sequencer
//  Description : Self-checking bench for global_reset_sequencer. Directed
//                timing scenarios followed by randomized stimulus, with every
//                cycle compared against a behavioural timing model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_global_reset_sequencer;

    localparam int SOURCES_WIDTH      = 2;
    localparam int STAGES             = 3;
    localparam int COUNTER_WIDTH      = 4;
    localparam int STAGE_GAP          = 5;
    localparam int SYNC_STAGES        = 2;
    localparam int LOCK_TIMEOUT_WIDTH = 6;

    localparam int HOLD_CYCLES = 1 << COUNTER_WIDTH;
    localparam int LOCK_CYCLES = 1 << LOCK_TIMEOUT_WIDTH;
    localparam int SYNC_LAT    = SYNC_STAGES + 1;

    // Probe selectors
    localparam int PR_PLL_UP  = 0;
    localparam int PR_ALL_LOW = 1;
    localparam int PR_TIMEOUT = 2;
    localparam int PR_DONE    = 3;
    localparam int PR_STAGE0  = 4;
    localparam int PR_STAGE1  = 5;
    localparam int PR_STAGE2  = 6;

    // Model phases
    localparam int PH_QUIET   = 0;
    localparam int PH_LOCK    = 1;
    localparam int PH_RELEASE = 2;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [SOURCES_WIDTH-1:0] resetn_sources;
    logic [SOURCES_WIDTH-1:0] source_mask;
    logic                     sw_reset_req;
    logic                     pll_locked;
    logic                     pll_resetn;
    logic [STAGES-1:0]        stage_resetn;
    logic                     sequence_done;
    logic                     lock_timeout;

    always #5 clk = ~clk;

    global_reset_sequencer #(
        .SOURCES_WIDTH      (SOURCES_WIDTH),
        .STAGES             (STAGES),
        .COUNTER_WIDTH      (COUNTER_WIDTH),
        .STAGE_GAP          (STAGE_GAP),
        .SYNC_STAGES        (SYNC_STAGES),
        .LOCK_TIMEOUT_WIDTH (LOCK_TIMEOUT_WIDTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .resetn_sources (resetn_sources),
        .source_mask    (source_mask),
        .sw_reset_req   (sw_reset_req),
        .pll_locked     (pll_locked),
        .pll_resetn     (pll_resetn),
        .stage_resetn   (stage_resetn),
        .sequence_done  (sequence_done),
        .lock_timeout   (lock_timeout)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: durations and a count of released stages.
    // Asynchronous inputs become visible to the sequencer two edges late.
    // ------------------------------------------------------------------------
    logic [SOURCES_WIDTH-1:0] m_src_seen, m_src_last;
    logic                     m_lock_seen, m_lock_last;
    int                       m_phase, m_quiet, m_wait, m_released, m_since;
    logic                     m_timeout;

    task automatic model_to_hold();
        m_phase    = PH_QUIET;
        m_quiet    = 0;
        m_wait     = 0;
        m_released = 0;
        m_since    = 0;
    endtask

    task automatic model_reset();
        model_to_hold();
        m_src_seen  = '0;
        m_src_last  = '0;
        m_lock_seen = 1'b0;
        m_lock_last = 1'b0;
        m_timeout   = 1'b0;
    endtask

    task automatic model_step();
        logic req;
        req = (|(source_mask & ~m_src_seen)) || sw_reset_req;
        case (m_phase)
            PH_QUIET: begin
                if (req) begin
                    m_quiet = 0;
                end else begin
                    m_quiet++;
                    if (m_quiet == HOLD_CYCLES) begin
                        m_phase = PH_LOCK;
                        m_wait  = 0;
                        m_quiet = 0;
                    end
                end
            end
            PH_LOCK: begin
                if (req) begin
                    model_to_hold();
                end else if (m_lock_seen) begin
                    m_phase    = PH_RELEASE;
                    m_released = 1;
                    m_since    = 0;
                end else begin
                    m_wait++;
                    if (m_wait == LOCK_CYCLES) begin
                        m_timeout = 1'b1;
                        model_to_hold();
                    end
                end
            end
            default: begin
                if (req || !m_lock_seen) begin
                    model_to_hold();
                end else if (m_released < STAGES) begin
                    m_since++;
                    if (m_since == STAGE_GAP) begin
                        m_released++;
                        m_since = 0;
                    end
                end
            end
        endcase
        m_src_seen  = m_src_last;
        m_src_last  = resetn_sources;
        m_lock_seen = m_lock_last;
        m_lock_last = pll_locked;
    endtask

    function automatic logic [5:0] model_outputs();
        logic [STAGES-1:0] st;
        st = STAGES'((1 << m_released) - 1);
        return {m_timeout, (m_released == STAGES), (m_phase != PH_QUIET), st};
    endfunction

    function automatic logic [5:0] dut_outputs();
        return {lock_timeout, sequence_done, pll_resetn, stage_resetn};
    endfunction

    function automatic logic probe(input int which);
        case (which)
            PR_PLL_UP:  return pll_resetn;
            PR_ALL_LOW: return !pll_resetn && (stage_resetn == '0) && !sequence_done;
            PR_TIMEOUT: return lock_timeout;
            PR_DONE:    return sequence_done;
            PR_STAGE0:  return stage_resetn[0];
            PR_STAGE1:  return stage_resetn[1];
            PR_STAGE2:  return stage_resetn[2];
            default:    return 1'b0;
        endcase
    endfunction

    // One clock: model advances on the edge, outputs compared on the
    // falling edge. Callers change inputs only between steps.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_value("cycle_outputs", 32'(dut_outputs()), 32'(model_outputs()));
    endtask

    task automatic cycles_until(input int which, input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            step();
            if (probe(which)) begin
                n = i;
                break;
            end
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic restart();
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_value("reset_outputs", 32'(dut_outputs()), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [SOURCES_WIDTH-1:0] pick;

        reset_n        = 1'b0;
        resetn_sources = '1;
        source_mask    = '1;
        sw_reset_req   = 1'b0;
        pll_locked     = 1'b0;
        model_reset();
        @(negedge clk);
        check_value("reset_outputs", 32'(dut_outputs()), 32'd0);
        reset_n = 1'b1;

        // Nominal sequence
        cycles_until(PR_PLL_UP, 40, n);
        check_value("nom_pll_rise", 32'(n), 32'(HOLD_CYCLES + SYNC_STAGES));
        repeat (9) step();
        pll_locked = 1'b1;
        cycles_until(PR_STAGE0, 20, n);
        check_value("nom_stage0", 32'(n), 32'(SYNC_LAT));
        cycles_until(PR_STAGE1, 20, n);
        check_value("nom_stage1", 32'(n), 32'(STAGE_GAP));
        cycles_until(PR_STAGE2, 20, n);
        check_value("nom_stage2", 32'(n), 32'(STAGE_GAP));
        check_value("nom_done_with_s2", 32'(sequence_done), 32'd1);

        // Mid-sequence abort from a source
        restart();
        cycles_until(PR_STAGE0, 40, n);
        check_value("abort_stage0", 32'(n), 32'(HOLD_CYCLES + SYNC_STAGES + 1));
        repeat (2) step();
        resetn_sources = 2'b01;
        cycles_until(PR_ALL_LOW, 10, n);
        check_value("abort_latency", 32'(n), 32'(SYNC_LAT));
        repeat (4) step();
        resetn_sources = '1;
        cycles_until(PR_PLL_UP, 40, n);
        check_value("abort_rehold", 32'(n), 32'(HOLD_CYCLES + SYNC_STAGES));

        // Lock timeout
        pll_locked = 1'b0;
        restart();
        cycles_until(PR_PLL_UP, 40, n);
        check_value("to_pll_rise", 32'(n), 32'(HOLD_CYCLES + SYNC_STAGES));
        cycles_until(PR_TIMEOUT, 100, n);
        check_value("to_expiry", 32'(n), 32'(LOCK_CYCLES));
        check_value("to_pll_low", 32'(pll_resetn), 32'd0);
        cycles_until(PR_PLL_UP, 40, n);
        check_value("to_rehold", 32'(n), 32'(HOLD_CYCLES));
        pll_locked = 1'b1;
        cycles_until(PR_DONE, 40, n);
        check_value("to_done", 32'(n), 32'(SYNC_LAT + (STAGES - 1) * STAGE_GAP));
        check_value("to_sticky", 32'(lock_timeout), 32'd1);

        // Masked source held low
        source_mask    = 2'b01;
        resetn_sources = 2'b01;
        restart();
        cycles_until(PR_DONE, 60, n);
        check_value("mask_done", 32'(n), 32'(HOLD_CYCLES + SYNC_STAGES + 1 + (STAGES - 1) * STAGE_GAP));
        resetn_sources = 2'b00;
        cycles_until(PR_ALL_LOW, 10, n);
        check_value("mask_abort", 32'(n), 32'(SYNC_LAT));
        resetn_sources = '1;
        source_mask    = '1;

        // Lock loss in DONE
        restart();
        cycles_until(PR_DONE, 60, n);
        check_value("ll_done", 32'(n), 32'(HOLD_CYCLES + SYNC_STAGES + 1 + (STAGES - 1) * STAGE_GAP));
        pll_locked = 1'b0;
        cycles_until(PR_ALL_LOW, 10, n);
        check_value("ll_latency", 32'(n), 32'(SYNC_LAT));
        cycles_until(PR_PLL_UP, 40, n);
        check_value("ll_rehold", 32'(n), 32'(HOLD_CYCLES));
        pll_locked = 1'b1;
        cycles_until(PR_DONE, 40, n);
        check_value("ll_redone", 32'(n), 32'(SYNC_LAT + (STAGES - 1) * STAGE_GAP));

        // Software reset, then a second pulse part-way through the hold
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        check_value("sw_latency", 32'(probe(PR_ALL_LOW)), 32'd1);
        repeat (7) step();
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        cycles_until(PR_PLL_UP, 40, n);
        check_value("sw_rehold", 32'(n), 32'(HOLD_CYCLES));
        cycles_until(PR_DONE, 40, n);
        check_value("sw_redone", 32'(n), 32'(1 + (STAGES - 1) * STAGE_GAP));

        // Randomized traffic against the model
        for (int ep = 0; ep < 250; ep++) begin
            int act;
            act = int'($urandom_range(0, 19));
            if (act <= 7) begin
                repeat ($urandom_range(1, 30)) step();
            end else if (act <= 9) begin
                pll_locked = ($urandom_range(0, 3) != 0);
                step();
            end else if (act <= 11) begin
                pick = SOURCES_WIDTH'(1) << $urandom_range(0, SOURCES_WIDTH - 1);
                resetn_sources = resetn_sources & ~pick;
                repeat ($urandom_range(1, 6)) step();
                resetn_sources = resetn_sources | pick;
                step();
            end else if (act <= 13) begin
                sw_reset_req = 1'b1;
                step();
                sw_reset_req = 1'b0;
                step();
            end else if (act == 14) begin
                source_mask = SOURCES_WIDTH'($urandom_range(0, (1 << SOURCES_WIDTH) - 1));
                step();
            end else if (act == 15) begin
                pll_locked = 1'b0;
                repeat (LOCK_CYCLES + HOLD_CYCLES + 20) step();
                pll_locked = 1'b1;
                step();
            end else if (act == 16) begin
                restart();
                step();
            end else begin
                repeat (40) step();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
